// File: rtl/dma_sched.sv
// dma_sched: round-robin scheduler sharing one DDR dma engine among NUM_REQ
// requesters. Latches the winner's direction/op/address, drives the dma
// enables, tracks dma side-band strobes for burst start/completion and returns
// a one-cycle done pulse to the winning requester.
//
// Optional feature macro: DMA_SCHED_WDOG_EN (watchdog on LAUNCH/WAIT, sets err).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   calib_done              DDR calibrated; gates new grants
//   req/req_wr/req_block    per-requester request level, direction, op type
//   req_addr                flattened 30-bit start addresses, requester i at [30i+29:30i]
//   gnt, done, busy         one-hot grant / completion pulses, transaction busy
//   writes_en, reads_en     dma burst enables
//   op_type, start_addr     dma op descriptor, stable until next grant
//   dma_ib_re, dma_cmd_en,  dma side-band activity used to detect start and
//   dma_cmd_instr, dma_ob_we  completion of the burst
//   err                     sticky watchdog error (constant 0 without the feature)
module dma_sched #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned BLOB_LEN    = 16,
  parameter int unsigned BLOCK_LEN   = 16,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  calib_done,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ-1:0]    req_block,
  input  logic [30*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic                  writes_en,
  output logic                  reads_en,
  output logic [2:0]            op_type,
  output logic [29:0]           start_addr,
  input  logic                  dma_ib_re,
  input  logic                  dma_cmd_en,
  input  logic [2:0]            dma_cmd_instr,
  input  logic                  dma_ob_we,
  output logic                  err
);

  localparam int unsigned AW     = 30;
  localparam int unsigned PW     = $clog2(NUM_REQ);
  localparam int unsigned MAXLEN = (BLOB_LEN > BLOCK_LEN) ? BLOB_LEN : BLOCK_LEN;
  localparam int unsigned CW     = $clog2(MAXLEN) + 1;
  localparam int unsigned WW     = $clog2(WDOG_CYCLES);

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  // Elaboration-time parameter sanity check
  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("dma_sched: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 wr_q, wr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 wen_q, wen_d;
  logic                 ren_q, ren_d;
  logic [2:0]           op_type_q, op_type_d;
  logic [AW-1:0]        start_addr_q, start_addr_d;

  logic [AW-1:0]        addr_arr [NUM_REQ];
  logic                 win_vld;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        cand_idx;
  int                   cand;
  logic                 complete;
  logic [CW-1:0]        tgt_len;

`ifdef DMA_SCHED_WDOG_EN
  logic [WW-1:0]        wd_q, wd_d;
  logic                 err_q, err_d;
`endif

  // Unflatten the requester address bus
  always_comb begin : unpack_addr
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
    end
  end

  // Round-robin search starting one past the last winner, with wrap
  always_comb begin : arb
    win_vld  = 1'b0;
    win_idx  = rr_ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand     = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
      cand_idx = PW'(cand);
      if (!win_vld && req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin : next_state
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    done_d       = '0;
    busy_d       = busy_q;
    wen_d        = wen_q;
    ren_d        = ren_q;
    op_type_d    = op_type_q;
    start_addr_d = start_addr_q;
    complete     = 1'b0;
    tgt_len      = op_type_q[0] ? CW'(BLOCK_LEN) : CW'(BLOB_LEN);
`ifdef DMA_SCHED_WDOG_EN
    wd_d         = wd_q;
    err_d        = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (calib_done && win_vld) begin
          state_d         = S_LAUNCH;
          rr_ptr_d        = win_idx;
          wr_d            = req_wr[win_idx];
          cnt_d           = '0;
          gnt_d[win_idx]  = 1'b1;
          busy_d          = 1'b1;
          wen_d           = req_wr[win_idx];
          ren_d           = !req_wr[win_idx];
          op_type_d       = {2'b00, req_block[win_idx]};
          start_addr_d    = addr_arr[win_idx];
`ifdef DMA_SCHED_WDOG_EN
          wd_d            = '0;
`endif
        end
      end

      // Enable drops on the start edge so the dma's sampling lag cannot relaunch
      S_LAUNCH: begin
        if (wr_q ? dma_ib_re : (dma_cmd_en && dma_cmd_instr == INSTR_RD)) begin
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wr_q) begin
          complete = dma_cmd_en && (dma_cmd_instr == INSTR_WR);
        end else if (dma_ob_we) begin
          cnt_d    = cnt_q + CW'(1);
          complete = (cnt_d == tgt_len);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      done_d[rr_ptr_q] = 1'b1;
      busy_d           = 1'b0;
      state_d          = S_IDLE;
    end

`ifdef DMA_SCHED_WDOG_EN
    // Watchdog releases the requester and flags a stuck dma
    if (state_q != S_IDLE && !complete) begin
      wd_d = wd_q + WW'(1);
      if (wd_q == WW'(WDOG_CYCLES - 1)) begin
        state_d          = S_IDLE;
        wen_d            = 1'b0;
        ren_d            = 1'b0;
        err_d            = 1'b1;
        done_d[rr_ptr_q] = 1'b1;
        busy_d           = 1'b0;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin : regs
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= PW'(NUM_REQ - 1);
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      op_type_q    <= '0;
      start_addr_q <= '0;
`ifdef DMA_SCHED_WDOG_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      op_type_q    <= op_type_d;
      start_addr_q <= start_addr_d;
`ifdef DMA_SCHED_WDOG_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign writes_en  = wen_q;
  assign reads_en   = ren_q;
  assign op_type    = op_type_q;
  assign start_addr = start_addr_q;

`ifdef DMA_SCHED_WDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_sched.sv
// Self-checking bench for dma_sched: directed scenarios plus randomized
// transactions checked against a simple round-robin reference model.
module tb_dma_sched;

  localparam int N      = 3;
  localparam int LEN_BL = 16;
  localparam int LEN_BK = 16;
  localparam int WDOG   = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            calib_done;
  logic [N-1:0]    req, req_wr, req_block;
  logic [30*N-1:0] req_addr;
  logic [N-1:0]    gnt, done;
  logic            busy, writes_en, reads_en, err;
  logic [2:0]      op_type;
  logic [29:0]     start_addr;
  logic            dma_ib_re, dma_cmd_en, dma_ob_we;
  logic [2:0]      dma_cmd_instr;

  int n_checks = 0;
  int n_pass   = 0;
  int model_last;

  logic [29:0] addr_v [N];
  logic        wr_v   [N];
  logic        blk_v  [N];

  dma_sched #(
    .NUM_REQ(N), .BLOB_LEN(LEN_BL), .BLOCK_LEN(LEN_BK), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
    .req(req), .req_wr(req_wr), .req_block(req_block), .req_addr(req_addr),
    .gnt(gnt), .done(done), .busy(busy),
    .writes_en(writes_en), .reads_en(reads_en),
    .op_type(op_type), .start_addr(start_addr),
    .dma_ib_re(dma_ib_re), .dma_cmd_en(dma_cmd_en),
    .dma_cmd_instr(dma_cmd_instr), .dma_ob_we(dma_ob_we), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot", {62'd0, $onehot0(gnt), $onehot0(done)}, 64'd3);
  endtask

  // Drive the per-requester attribute arrays onto the DUT buses
  task automatic apply_attrs();
    for (int i = 0; i < N; i++) begin
      req_wr[i]               = wr_v[i];
      req_block[i]            = blk_v[i];
      req_addr[i*30 +: 30]    = addr_v[i];
    end
  endtask

  // Reference arbitration: first requester after the last winner, with wrap
  function automatic int rr_next(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Wait for a grant, act as the dma for one burst, and check the outcome.
  // Returns in the cycle where done is visible (the scheduler is then idle).
  task automatic run_txn(input int w, input logic wr, input logic blk,
                         input logic [29:0] addr, input int max_gap, output int lat);
    logic [N-1:0] oh;
    int n, len;
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    len = blk ? LEN_BK : LEN_BL;
    n = 0;
    while (gnt === '0 && n < 40) begin
      step();
      n++;
    end
    lat = n;
    chk("gnt", 64'(gnt), 64'(oh));
    chk("busy_at_gnt", 64'(busy), 64'd1);
    chk("enables", 64'({writes_en, reads_en}), 64'({wr, !wr}));
    chk("op_type", 64'(op_type), 64'({2'b00, blk}));
    chk("start_addr", 64'(start_addr), 64'(addr));
    model_last = w;
    repeat ($urandom_range(max_gap, 0)) begin
      step();
      chk("enable_hold", 64'({writes_en, reads_en}), 64'({wr, !wr}));
    end
    if (wr) dma_ib_re = 1'b1;
    else begin
      dma_cmd_en    = 1'b1;
      dma_cmd_instr = 3'b001;
    end
    step();
    dma_ib_re = 1'b0; dma_cmd_en = 1'b0; dma_cmd_instr = 3'b000;
    chk("enable_drop", 64'({writes_en, reads_en}), 64'd0);
    chk("desc_hold", 64'({op_type, start_addr}), 64'({2'b00, blk, addr}));
    if (wr) begin
      repeat ($urandom_range(max_gap, 0)) begin
        step();
        chk("no_early_done", 64'(done), 64'd0);
      end
      dma_cmd_en = 1'b1; dma_cmd_instr = 3'b000;
      step();
      dma_cmd_en = 1'b0;
    end else begin
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(max_gap, 0)) step();
        dma_ob_we = 1'b1;
        step();
        dma_ob_we = 1'b0;
        if (i < len - 1) chk("no_early_done", 64'(done), 64'd0);
      end
    end
    chk("done", 64'(done), 64'(oh));
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, n, w, seen;
    logic [N-1:0] rv, oh;

    reset_n = 1'b0; calib_done = 1'b1;
    req = '0; req_wr = '0; req_block = '0; req_addr = '0;
    dma_ib_re = 1'b0; dma_cmd_en = 1'b0; dma_cmd_instr = 3'b000; dma_ob_we = 1'b0;
    model_last = N - 1;
    #3;
    chk("reset_ctl", 64'({gnt, done, busy, writes_en, reads_en, err, op_type}), 64'd0);
    chk("reset_addr", 64'(start_addr), 64'd0);
    step(); step();
    reset_n = 1'b1;
    step();

    // All requesters held, block writes: strict rotation 0,1,2,0,1,2
    for (int i = 0; i < N; i++) begin
      wr_v[i] = 1'b1; blk_v[i] = 1'b1; addr_v[i] = 30'(32'h1000 * (i + 1));
    end
    apply_attrs();
    req = '1;
    for (int t = 0; t < 6; t++) begin
      w = t % N;
      run_txn(w, 1'b1, 1'b1, addr_v[w], 2, lat);
    end
    req = '0;

    // No grant while calibration is pending, then prompt grant
    calib_done = 1'b0;
    wr_v[0] = 1'b0; blk_v[0] = 1'b0; addr_v[0] = 30'h2A0;
    apply_attrs();
    req = 3'b001;
    seen = 0;
    repeat (50) begin
      step();
      if (gnt !== '0 || busy !== 1'b0) seen++;
    end
    chk("no_gnt_uncalibrated", 64'(seen), 64'd0);
    calib_done = 1'b1;
    run_txn(0, 1'b0, 1'b0, 30'h2A0, 1, lat);
    req = '0;
    chk("calib_latency_le2", 64'(lat <= 2), 64'd1);

    // Single blob read by requester 1 at 0x100
    wr_v[1] = 1'b0; blk_v[1] = 1'b0; addr_v[1] = 30'h100;
    apply_attrs();
    req = 3'b010;
    run_txn(1, 1'b0, 1'b0, 30'h100, 0, lat);
    req = '0;
    chk("gnt_latency", 64'(lat), 64'd1);

    // Spurious ob_we while idle, then a read with spaced ob_we pulses
    repeat (3) begin
      dma_ob_we = 1'b1; step(); dma_ob_we = 1'b0; step();
    end
    wr_v[2] = 1'b0; blk_v[2] = 1'b1; addr_v[2] = 30'h3FF_FFC0;
    apply_attrs();
    req = 3'b100;
    run_txn(2, 1'b0, 1'b1, 30'h3FF_FFC0, 3, lat);
    req = '0;

    // Reset in the middle of a read after 5 ob_we pulses
    wr_v[0] = 1'b0; blk_v[0] = 1'b0; addr_v[0] = 30'h555;
    apply_attrs();
    req = 3'b001;
    n = 0;
    while (gnt === '0 && n < 10) begin step(); n++; end
    chk("mid_gnt", 64'(gnt), 64'd1);
    req = '0;
    dma_cmd_en = 1'b1; dma_cmd_instr = 3'b001; step();
    dma_cmd_en = 1'b0; dma_cmd_instr = 3'b000;
    repeat (5) begin dma_ob_we = 1'b1; step(); dma_ob_we = 1'b0; end
    reset_n = 1'b0;
    #1;
    chk("async_reset_ctl", 64'({gnt, done, busy, writes_en, reads_en, err, op_type}), 64'd0);
    chk("async_reset_addr", 64'(start_addr), 64'd0);
    step(); step();
    reset_n = 1'b1;
    model_last = N - 1;
    seen = 0;
    repeat (20) begin
      step();
      if (done !== '0 || gnt !== '0) seen++;
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);
    // Pointer back at NUM_REQ-1: requester 0 beats 2
    wr_v[0] = 1'b1; blk_v[0] = 1'b0; addr_v[0] = 30'h40;
    wr_v[2] = 1'b1; blk_v[2] = 1'b1; addr_v[2] = 30'h80;
    apply_attrs();
    req = 3'b101;
    run_txn(0, 1'b1, 1'b0, 30'h40, 1, lat);
    req = 3'b100;
    run_txn(2, 1'b1, 1'b1, 30'h80, 1, lat);
    req = '0;

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 14; t++) begin
      rv = N'($urandom_range((1 << N) - 1, 1));
      for (int i = 0; i < N; i++) begin
        wr_v[i]   = 1'($urandom);
        blk_v[i]  = 1'($urandom);
        addr_v[i] = 30'($urandom);
      end
      apply_attrs();
      req = rv;
      w = rr_next(rv, model_last);
      run_txn(w, wr_v[w], blk_v[w], addr_v[w], 3, lat);
      chk("rand_latency", 64'(lat), 64'd1);
    end
    req = '0;
    step();

`ifdef DMA_SCHED_WDOG_EN
    // dma never completes: watchdog releases requester 1 and sets err
    wr_v[1] = 1'b1; blk_v[1] = 1'b0; addr_v[1] = 30'h7;
    apply_attrs();
    req = 3'b010;
    n = 0;
    while (gnt === '0 && n < 10) begin step(); n++; end
    chk("wd_gnt", 64'(gnt), 64'd2);
    req = '0;
    oh = 3'b010;
    repeat (WDOG - 1) step();
    chk("wd_no_done_early", 64'({done, err}), 64'd0);
    step();
    chk("wd_done", 64'(done), 64'(oh));
    chk("wd_err", 64'(err), 64'd1);
    chk("wd_release", 64'({busy, writes_en, reads_en}), 64'd0);
    model_last = 1;
    wr_v[2] = 1'b0; blk_v[2] = 1'b0; addr_v[2] = 30'h99;
    apply_attrs();
    req = 3'b100;
    run_txn(2, 1'b0, 1'b0, 30'h99, 1, lat);
    req = '0;
    chk("wd_err_sticky", 64'(err), 64'd1);
`else
    chk("err_tied_low", 64'(err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
